// File: rtl/bsg_link_rx_assembler.sv
// Receive-side assembler for the off-chip link.
// Pairs two 32-bit beats ({ch1, ch0}) into one 64-bit word and buffers the
// words in a small circular FIFO. The FIFO is presented to the core with a
// valid/yumi handshake. Credit goes back to the sender by toggling io_token_o
// once per TOKEN_BATCH consumed words.
module bsg_link_rx_assembler #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TOKEN_BATCH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          io_valid_i,
  input  logic [15:0]                   io_data_ch0_i,
  input  logic [15:0]                   io_data_ch1_i,
  output logic                          core_valid_o,
  output logic [63:0]                   core_data_o,
  input  logic                          core_yumi_i,
  output logic                          io_token_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic             phase_reg;
  logic [31:0]      half_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [63:0]      mem_reg [FIFO_DEPTH];
  logic             overflow_reg;
  logic             token_reg;

  logic [31:0]      beat;
  logic             wr_req;
  logic             yumi_eff;
  logic             wr_accept;
  logic             batch_done;

  assign beat = {io_data_ch1_i, io_data_ch0_i};

  // A yumi against an empty FIFO is illegal; it is masked so that it can
  // never corrupt the pointers, the count or the token counter.
  assign yumi_eff = core_yumi_i & (count_reg != '0);

  // The second beat of a pair completes a word.
  assign wr_req = io_valid_i & phase_reg;

  // A full FIFO still accepts a word when the head is consumed in the same
  // cycle, so back-to-back traffic with a yumi every cycle never drops.
  assign wr_accept = wr_req & ((count_reg < DEPTH_C) | yumi_eff);

  // Beat pairing: capture the low half on phase 0, emit the word on phase 1.
  // The phase returns to 0 even when the completed word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= 1'b0;
      half_reg  <= '0;
    end else if (io_valid_i) begin
      if (!phase_reg) begin
        half_reg <= beat;
      end
      phase_reg <= ~phase_reg;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (yumi_eff) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (wr_accept && !yumi_eff) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (!wr_accept && yumi_eff) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // Word storage. A slot is always written before it is read, so the
  // storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_reg[wr_ptr_reg] <= {beat, half_reg};
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_req && !wr_accept) begin
      overflow_reg <= 1'b1;
    end
  end

  // Consume counter. With a batch of one, every consumed word toggles the
  // token, so no counter is needed at all.
  generate
    if (TOKEN_BATCH > 1) begin : g_batch
      localparam int TB_W = $clog2(TOKEN_BATCH);
      logic [TB_W-1:0] consume_reg;

      // Count consumed words; the natural wrap returns the counter to 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          consume_reg <= '0;
        end else if (yumi_eff) begin
          consume_reg <= consume_reg + TB_W'(1);
        end
      end

      assign batch_done = yumi_eff & (consume_reg == TB_W'(TOKEN_BATCH - 1));
    end else begin : g_single
      assign batch_done = yumi_eff;
    end
  endgenerate

  // Credit return: toggle once per completed batch of consumed words.
  always_ff @(posedge clk) begin
    if (rst) begin
      token_reg <= 1'b0;
    end else if (batch_done) begin
      token_reg <= ~token_reg;
    end
  end

  assign core_valid_o = (count_reg != '0);
  assign core_data_o  = mem_reg[rd_ptr_reg];
  assign io_token_o   = token_reg;
  assign overflow_o   = overflow_reg;
  assign fill_o       = count_reg;

endmodule

// File: tb/tb_bsg_link_rx_assembler.sv
// Directed and random bench for bsg_link_rx_assembler (FIFO_DEPTH 8,
// TOKEN_BATCH 4). Inputs change 1 ns after the rising edge; outputs are
// sampled at the same point, so they show the state after that edge.
module tb_bsg_link_rx_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_valid_i;
  logic [15:0] io_data_ch0_i;
  logic [15:0] io_data_ch1_i;
  logic        core_valid_o;
  logic [63:0] core_data_o;
  logic        core_yumi_i;
  logic        io_token_o;
  logic        overflow_o;
  logic [3:0]  fill_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          verbose  = 1'b1;

  // Reference state
  logic [63:0] m_q[$];
  bit          m_phase;
  logic [31:0] m_half;
  bit          m_ovf;
  int          m_consumed;

  bsg_link_rx_assembler #(
    .FIFO_DEPTH (8),
    .TOKEN_BATCH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_valid_i   (io_valid_i),
    .io_data_ch0_i(io_data_ch0_i),
    .io_data_ch1_i(io_data_ch1_i),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_yumi_i  (core_yumi_i),
    .io_token_o   (io_token_o),
    .overflow_o   (overflow_o),
    .fill_o       (fill_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word k is built from beats {k+0x100, k} then {k+0x300, k+0x200}.
  function automatic logic [63:0] wexp(input int k);
    logic [15:0] b0, b1, b2, b3;
    b0 = 16'(k);
    b1 = 16'(k + 'h100);
    b2 = 16'(k + 'h200);
    b3 = 16'(k + 'h300);
    return {b3, b2, b1, b0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    io_valid_i = 1'b0;
    core_yumi_i = 1'b0;
    m_q.delete();
    m_phase = 1'b0;
    m_half = '0;
    m_ovf = 1'b0;
    m_consumed = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle with the given inputs; the reference state follows along.
  task automatic cycle(input bit v, input logic [15:0] c1, input logic [15:0] c0, input bit y);
    bit full_before;
    bit yv;
    io_valid_i    = v;
    io_data_ch1_i = c1;
    io_data_ch0_i = c0;
    core_yumi_i   = y;
    if (y && m_q.size() == 0) check_eq("yumi_while_empty", 64'(y), 64'd0);
    full_before = (m_q.size() == 8);
    yv = y && (m_q.size() != 0);
    if (yv) begin
      void'(m_q.pop_front());
      m_consumed++;
    end
    if (v) begin
      if (m_phase) begin
        if (!full_before || yv) m_q.push_back({c1, c0, m_half});
        else m_ovf = 1'b1;
        m_phase = 1'b0;
      end else begin
        m_half = {c1, c0};
        m_phase = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (verbose)
      $display("txn t=%0t v=%0b beat=%h_%h yumi=%0b -> valid=%0b fill=%0d head=%h tok=%0b ovf=%0b",
               $time, v, c1, c0, y, core_valid_o, fill_o, core_data_o, io_token_o, overflow_o);
    io_valid_i  = 1'b0;
    core_yumi_i = 1'b0;
  endtask

  task automatic send_word(input int k, input bit y_on_second);
    cycle(1'b1, 16'(k + 'h100), 16'(k), 1'b0);
    cycle(1'b1, 16'(k + 'h300), 16'(k + 'h200), y_on_second);
  endtask

  // Compare every output against the reference state.
  task automatic check_state(input string tag);
    check_eq({tag, ".valid"}, 64'(core_valid_o), 64'(m_q.size() != 0));
    check_eq({tag, ".fill"},  64'(fill_o),       64'(m_q.size()));
    check_eq({tag, ".token"}, 64'(io_token_o),   64'((m_consumed / 4) % 2));
    check_eq({tag, ".ovf"},   64'(overflow_o),   64'(m_ovf));
    if (m_q.size() != 0) check_eq({tag, ".data"}, core_data_o, m_q[0]);
  endtask

  initial begin
    io_data_ch0_i = '0;
    io_data_ch1_i = '0;
    do_reset();

    // Reset state
    check_eq("rst.valid", 64'(core_valid_o), 64'd0);
    check_eq("rst.fill",  64'(fill_o),       64'd0);
    check_eq("rst.token", 64'(io_token_o),   64'd0);
    check_eq("rst.ovf",   64'(overflow_o),   64'd0);

    // Single word, visible the cycle after the second beat
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0);
    check_eq("single.half_valid", 64'(core_valid_o), 64'd0);
    cycle(1'b1, 16'h3333, 16'h4444, 1'b0);
    check_eq("single.valid", 64'(core_valid_o), 64'd1);
    check_eq("single.data",  core_data_o, 64'h3333_4444_1111_2222);
    check_eq("single.fill",  64'(fill_o), 64'd1);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    check_eq("single.popped", 64'(core_valid_o), 64'd0);
    check_eq("single.fill0",  64'(fill_o), 64'd0);

    // Gapped beats
    cycle(1'b1, 16'haaaa, 16'hbbbb, 1'b0);
    repeat (3) cycle(1'b0, 16'hffff, 16'hffff, 1'b0);
    check_eq("gap.no_word", 64'(core_valid_o), 64'd0);
    cycle(1'b1, 16'hcccc, 16'hdddd, 1'b0);
    check_eq("gap.data", core_data_o, 64'hcccc_dddd_aaaa_bbbb);
    cycle(1'b0, 16'h0, 16'h0, 1'b1);
    cycle(1'b1, 16'h5555, 16'h6666, 1'b0);
    check_eq("gap.phase0", 64'(fill_o), 64'd0);
    cycle(1'b1, 16'h7777, 16'h8888, 1'b0);
    check_eq("gap.next_data", core_data_o, 64'h7777_8888_5555_6666);
    check_state("gap");

    // Fill, write-at-full with yumi, overflow, drain with tokens
    do_reset();
    for (int k = 1; k <= 8; k++) send_word(k, 1'b0);
    check_eq("full.fill", 64'(fill_o), 64'd8);
    check_eq("full.ovf",  64'(overflow_o), 64'd0);
    check_eq("full.head", core_data_o, wexp(1));
    send_word(9, 1'b1);
    check_eq("full_yumi.fill", 64'(fill_o), 64'd8);
    check_eq("full_yumi.ovf",  64'(overflow_o), 64'd0);
    check_eq("full_yumi.head", core_data_o, wexp(2));
    send_word(10, 1'b0);
    check_eq("drop.fill", 64'(fill_o), 64'd8);
    check_eq("drop.ovf",  64'(overflow_o), 64'd1);
    check_eq("drop.head", core_data_o, wexp(2));
    for (int i = 0; i < 8; i++) begin
      check_eq("drain.data", core_data_o, wexp(i + 2));
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
      check_state("drain");
    end
    // Nine words consumed: toggled after the 4th and the 8th
    check_eq("drain.token", 64'(io_token_o), 64'd0);
    check_eq("drain.empty", 64'(core_valid_o), 64'd0);
    check_eq("drain.ovf_sticky", 64'(overflow_o), 64'd1);

    // Token toggles, then reset mid-word with contents
    do_reset();
    for (int k = 1; k <= 5; k++) send_word(k, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1);
    check_eq("tok.after4", 64'(io_token_o), 64'd1);
    check_eq("tok.fill1",  64'(fill_o), 64'd1);
    cycle(1'b1, 16'h1234, 16'h5678, 1'b0);
    do_reset();
    check_eq("rstmid.token", 64'(io_token_o), 64'd0);
    check_eq("rstmid.fill",  64'(fill_o), 64'd0);
    check_eq("rstmid.valid", 64'(core_valid_o), 64'd0);
    cycle(1'b1, 16'haaaa, 16'h0001, 1'b0);
    cycle(1'b1, 16'hbbbb, 16'h0002, 1'b0);
    check_eq("rstmid.data",   core_data_o, 64'hbbbb_0002_aaaa_0001);
    check_eq("rstmid.fill1",  64'(fill_o), 64'd1);
    check_eq("rstmid.token0", 64'(io_token_o), 64'd0);

    // Random stress against the reference queue
    verbose = 1'b0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      bit v, y;
      v = ($urandom_range(0, 1) == 1);
      y = core_valid_o && ($urandom_range(0, 3) != 0);
      cycle(v, 16'($urandom), 16'($urandom), y);
      check_state("stress");
    end
    $display("stress done: %0d words consumed", m_consumed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
